// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multicycle RV32I core: one state per datapath step, with a
// memory-ready handshake on every memory access and a sticky trap on undecodable instructions.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       instret,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StTrap     = 4'd11
  } state_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  state_e state_q, state_d;
  logic   illegal_q;

  // ALU operation for the execute states; funct3_ok flags an encoding we cannot run.
  logic [2:0] alu_dec;
  logic       funct3_ok;

  always_comb begin
    alu_dec   = AluAdd;
    funct3_ok = 1'b1;
    case (funct3)
      3'b000:  alu_dec = (funct7b5 && op[5]) ? AluSub : AluAdd;
      3'b010:  alu_dec = AluSlt;
      3'b110:  alu_dec = AluOr;
      3'b111:  alu_dec = AluAnd;
      default: funct3_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBeq:           state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
      StMemRead: begin
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb:    state_d = StFetch;
      StMemWrite: begin
        if (mem_ready) state_d = StFetch;
      end
      StExecR, StExecI: state_d = funct3_ok ? StAluWb : StTrap;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  // Enables are built ungated here and masked by reset below so a held reset writes nothing.
  logic pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, instret_raw;

  always_comb begin
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    instret_raw   = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    imm_src       = 2'b00;
    alu_control   = AluAdd;
    unique case (state_q)
      StFetch: begin
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_write_raw = mem_ready;
        ir_write_raw = mem_ready;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = op[5] ? 2'b01 : 2'b00;
      end
      StMemRead: begin
        adr_src = 1'b1;
      end
      StMemWb: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        instret_raw   = 1'b1;
      end
      StMemWrite: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        instret_raw   = mem_ready;
      end
      StExecR: begin
        alu_src_a   = 2'b10;
        alu_control = funct3_ok ? alu_dec : AluAdd;
      end
      StExecI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = funct3_ok ? alu_dec : AluAdd;
      end
      StAluWb: begin
        reg_write_raw = 1'b1;
        instret_raw   = 1'b1;
      end
      StBeq: begin
        alu_src_a    = 2'b10;
        alu_control  = AluSub;
        pc_write_raw = zero;
        instret_raw  = 1'b1;
      end
      StJal: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        imm_src      = 2'b11;
        pc_write_raw = 1'b1;
      end
      StTrap: begin
      end
      default: begin
      end
    endcase
  end

  assign pc_write  = pc_write_raw & ~reset;
  assign mem_write = mem_write_raw & ~reset;
  assign ir_write  = ir_write_raw & ~reset;
  assign reg_write = reg_write_raw & ~reset;
  assign instret   = instret_raw & ~reset;
  assign illegal   = illegal_q;
  assign state     = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == StTrap);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each stimulus cycle queues its hand-computed expected
// outputs; an independent monitor pops and compares them mid-cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, instret, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_src    (imm_src),
    .alu_control(alu_control),
    .reg_write  (reg_write),
    .instret    (instret),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, pcw, adr, mw, irw, rs, sa, sb, is, alu, rw, ir, ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc_n = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc_n, act, expv);
  endtask

  // Monitor: compares whatever expectation the stimulus queued for the current cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("state", int'(state), e.st);
      chk("pc_write", int'(pc_write), e.pcw);
      chk("adr_src", int'(adr_src), e.adr);
      chk("mem_write", int'(mem_write), e.mw);
      chk("ir_write", int'(ir_write), e.irw);
      chk("result_src", int'(result_src), e.rs);
      chk("alu_src_a", int'(alu_src_a), e.sa);
      chk("alu_src_b", int'(alu_src_b), e.sb);
      chk("imm_src", int'(imm_src), e.is);
      chk("alu_control", int'(alu_control), e.alu);
      chk("reg_write", int'(reg_write), e.rw);
      chk("instret", int'(instret), e.ir);
      chk("illegal", int'(illegal), e.ill);
      cyc_n++;
    end
  end

  // One clock cycle: drive inputs just after the edge and queue the expected outputs.
  task automatic cyc(input int rst, mr, z, st, pcw, adr, mw, irw, rs, sa, sb, is, alu,
                     rw, ir, ill);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst[0];
    mem_ready = mr[0];
    zero      = z[0];
    e.st = st;  e.pcw = pcw; e.adr = adr; e.mw = mw;  e.irw = irw;
    e.rs = rs;  e.sa = sa;   e.sb = sb;   e.is = is;  e.alu = alu;
    e.rw = rw;  e.ir = ir;   e.ill = ill;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  //          rst mr z  st pcw adr mw irw rs sa sb is alu rw ir ill
  initial begin
    // Reset held with mem_ready=1: FETCH selects, every enable masked.
    cyc(1, 1, 0,  0, 0, 0, 0, 0,  2, 0, 2, 0, 0,  0, 0, 0);
    // R-type add
    instr(7'b0110011, 3'b000, 1'b0);
    cyc(0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 2, 0,  0, 0, 0);
    cyc(0, 1, 0,  6, 0, 0, 0, 0,  0, 2, 0, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  8, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0);
    // R-type sub
    instr(7'b0110011, 3'b000, 1'b1);
    cyc(0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 2, 0,  0, 0, 0);
    cyc(0, 1, 0,  6, 0, 0, 0, 0,  0, 2, 0, 0, 1,  0, 0, 0);
    cyc(0, 1, 0,  8, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0);
    // R-type slt then and (ALU decode only)
    instr(7'b0110011, 3'b010, 1'b0);
    cyc(0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 2, 0,  0, 0, 0);
    cyc(0, 1, 0,  6, 0, 0, 0, 0,  0, 2, 0, 0, 5,  0, 0, 0);
    cyc(0, 1, 0,  8, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0);
    instr(7'b0110011, 3'b111, 1'b0);
    cyc(0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 2, 0,  0, 0, 0);
    cyc(0, 1, 0,  6, 0, 0, 0, 0,  0, 2, 0, 0, 2,  0, 0, 0);
    cyc(0, 1, 0,  8, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0);
    // I-type or; then addi with funct7b5=1 must stay add since op[5]=0
    instr(7'b0010011, 3'b110, 1'b1);
    cyc(0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 2, 0,  0, 0, 0);
    cyc(0, 1, 0,  7, 0, 0, 0, 0,  0, 2, 1, 0, 3,  0, 0, 0);
    cyc(0, 1, 0,  8, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0);
    instr(7'b0010011, 3'b000, 1'b1);
    cyc(0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 2, 0,  0, 0, 0);
    cyc(0, 1, 0,  7, 0, 0, 0, 0,  0, 2, 1, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  8, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0);
    // lw with two stall cycles in MEMREAD
    instr(7'b0000011, 3'b010, 1'b0);
    cyc(0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 2, 0,  0, 0, 0);
    cyc(0, 1, 0,  2, 0, 0, 0, 0,  0, 2, 1, 0, 0,  0, 0, 0);
    cyc(0, 0, 0,  3, 0, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
    cyc(0, 0, 0,  3, 0, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  3, 0, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  4, 0, 0, 0, 0,  1, 0, 0, 0, 0,  1, 1, 0);
    // sw with a FETCH stall and a MEMWRITE stall
    instr(7'b0100011, 3'b010, 1'b0);
    cyc(0, 0, 0,  0, 0, 0, 0, 0,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 2, 0,  0, 0, 0);
    cyc(0, 1, 0,  2, 0, 0, 0, 0,  0, 2, 1, 1, 0,  0, 0, 0);
    cyc(0, 0, 0,  5, 0, 1, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  5, 0, 1, 1, 0,  0, 0, 0, 0, 0,  0, 1, 0);
    // beq taken, then not taken
    instr(7'b1100011, 3'b000, 1'b0);
    cyc(0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 2, 0,  0, 0, 0);
    cyc(0, 1, 1,  9, 1, 0, 0, 0,  0, 2, 0, 0, 1,  0, 1, 0);
    cyc(0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 2, 0,  0, 0, 0);
    cyc(0, 1, 0,  9, 0, 0, 0, 0,  0, 2, 0, 0, 1,  0, 1, 0);
    // jal
    instr(7'b1101111, 3'b000, 1'b0);
    cyc(0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 2, 0,  0, 0, 0);
    cyc(0, 1, 0, 10, 1, 0, 0, 0,  0, 1, 2, 3, 0,  0, 0, 0);
    cyc(0, 1, 0,  8, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0);
    // sw abandoned by reset while stalled in MEMWRITE
    instr(7'b0100011, 3'b010, 1'b0);
    cyc(0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 2, 0,  0, 0, 0);
    cyc(0, 1, 0,  2, 0, 0, 0, 0,  0, 2, 1, 1, 0,  0, 0, 0);
    cyc(0, 0, 0,  5, 0, 1, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0);
    cyc(1, 1, 0,  0, 0, 0, 0, 0,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    // Illegal opcode: TRAP absorbs, no enables even with mem_ready and zero high
    instr(7'b0110111, 3'b000, 1'b0);
    cyc(0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 2, 0,  0, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 1, 11, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1);
    cyc(1, 1, 0,  0, 0, 0, 0, 0,  2, 0, 2, 0, 0,  0, 0, 0);
    // R-type with unsupported funct3 traps out of EXECR
    instr(7'b0110011, 3'b001, 1'b0);
    cyc(0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 2, 0,  0, 0, 0);
    cyc(0, 1, 0,  6, 0, 0, 0, 0,  0, 2, 0, 0, 0,  0, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 1, 11, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1);
    cyc(1, 1, 0,  0, 0, 0, 0, 0,  2, 0, 2, 0, 0,  0, 0, 0);
    cyc(0, 0, 0,  0, 0, 0, 0, 0,  2, 0, 2, 0, 0,  0, 0, 0);

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
